if_fetch_queue: RTL and testbench

//  Instruction-fetch stage of the pipeline: owns the PC, fetches words from imem over a req/ack

---
 rtl/if_fetch_queue_pkg.sv | 29 ++
 rtl/if_fetch_queue_inst_fifo.sv | 86 ++++++++
 rtl/if_fetch_queue.sv | 159 +++++++++++++++
 tb/tb_if_fetch_queue.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/if_fetch_queue_pkg.sv
// ---------------------------------------------------------------------------
// if_fetch_queue_pkg
//   Shared definitions for the instruction-fetch queue:
//     NOP_INST       - encoding of addi x0,x0,0, shown to decode when empty
//     fetch_state_e  - fetch FSM encoding (IDLE, FETCH, STALL, DISCARD)
//     fetch_entry_t  - one queued {pc, inst} pair (64 bits)
//     word_align()   - clears the byte-offset bits of an address
// ---------------------------------------------------------------------------
package if_fetch_queue_pkg;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_FETCH   = 2'd1,
    ST_STALL   = 2'd2,
    ST_DISCARD = 2'd3
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/if_fetch_queue_inst_fifo.sv
// ---------------------------------------------------------------------------
// if_fetch_queue_inst_fifo
//   Small synchronous FIFO holding fetched {pc, inst} entries. The head entry
//   is read combinationally from the storage array so a word pushed at one
//   edge is visible to decode right after that edge.
// Ports:
//   clk      in   clock
//   clrn     in   synchronous active-low reset (empties the FIFO)
//   push_i   in   write data_i at the tail
//   pop_i    in   drop the head entry (ignored when empty)
//   flush_i  in   empty the FIFO; overrides push and pop
//   data_i   in   WIDTH-bit entry to write
//   head_o   out  current head entry (stale contents when empty)
//   count_o  out  occupancy, 0..DEPTH
// ---------------------------------------------------------------------------
module if_fetch_queue_inst_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 64
) (
  input  logic                   clk,
  input  logic                   clrn,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic                   flush_i,
  input  logic [WIDTH-1:0]       data_i,
  output logic [WIDTH-1:0]       head_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] FULL_C = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push_ok, pop_ok;

  assign pop_ok  = pop_i && (count_q != '0);
  // A full FIFO can still accept a push when the head leaves in the same cycle.
  assign push_ok = push_i && ((count_q != FULL_C) || pop_ok);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      // Pointers are PW bits wide, so they wrap modulo DEPTH for free.
      if (push_ok) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + PW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!clrn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; count_q alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push_ok && !flush_i) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/if_fetch_queue.sv
// ---------------------------------------------------------------------------
// if_fetch_queue
//   Instruction-fetch stage. Owns the PC, fetches words from imem over a
//   req/ack handshake, queues {pc, inst} pairs and presents the head to
//   decode with valid/ready. A taken branch/jump (redirect) flushes the queue
//   and restarts fetching at the new target.
// Ports:
//   clk          in   clock
//   clrn         in   synchronous active-low reset
//   imem_req     out  fetch request, held with stable imem_addr until ack
//   imem_addr    out  word address of the outstanding request
//   imem_ack     in   one-cycle accept, imem_rdata valid in the same cycle
//   imem_rdata   in   fetched instruction
//   redirect     in   flush and refetch from redirect_pc
//   redirect_pc  in   new fetch target (byte offset bits ignored)
//   d_valid      out  head entry valid
//   d_ready      in   decode consumes the head when d_valid & d_ready
//   d_inst       out  head instruction, NOP when empty
//   d_pc         out  head PC, 0 when empty
//   q_count      out  queue occupancy
// ---------------------------------------------------------------------------
module if_fetch_queue
  import if_fetch_queue_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP      = NOP_INST
) (
  input  logic                   clk,
  input  logic                   clrn,
  output logic                   imem_req,
  output logic [31:0]            imem_addr,
  input  logic                   imem_ack,
  input  logic [31:0]            imem_rdata,
  input  logic                   redirect,
  input  logic [31:0]            redirect_pc,
  output logic                   d_valid,
  input  logic                   d_ready,
  output logic [31:0]            d_inst,
  output logic [31:0]            d_pc,
  output logic [$clog2(DEPTH):0] q_count
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  fetch_state_e  state_q, state_d;
  logic [31:0]   req_pc_q, req_pc_d;   // address currently on imem_addr
  logic [31:0]   next_pc_q, next_pc_d; // target to fetch once IDLE/DISCARD resolve

  logic          fifo_push, fifo_pop, fifo_flush;
  logic [CW-1:0] fifo_count;
  fetch_entry_t  fifo_head;
  fetch_entry_t  push_entry;
  logic [CW-1:0] count_after_pop;
  logic [31:0]   redirect_tgt;

  assign redirect_tgt = word_align(redirect_pc);
  assign push_entry   = '{pc: req_pc_q, inst: imem_rdata};

  // Decode consumes the head whenever it is valid and ready, even during a
  // redirect; squashing that instruction is decode's job.
  assign fifo_pop        = d_valid && d_ready;
  assign count_after_pop = fifo_count - CW'(fifo_pop);

  always_comb begin
    state_d    = state_q;
    req_pc_d   = req_pc_q;
    next_pc_d  = next_pc_q;
    fifo_push  = 1'b0;
    fifo_flush = 1'b0;
    case (state_q)
      ST_IDLE: begin
        state_d  = ST_FETCH;
        req_pc_d = redirect ? redirect_tgt : next_pc_q;
        if (redirect) begin
          next_pc_d  = redirect_tgt;
          fifo_flush = 1'b1;
        end
      end
      ST_FETCH: begin
        if (redirect) begin
          fifo_flush = 1'b1;
          if (imem_ack) begin
            req_pc_d = redirect_tgt;
          end else begin
            // The request cannot be withdrawn: keep it stable, swallow its
            // response, then move to the new target.
            next_pc_d = redirect_tgt;
            state_d   = ST_DISCARD;
          end
        end else if (imem_ack) begin
          fifo_push = 1'b1;
          req_pc_d  = req_pc_q + 32'd4;
          // Keep issuing only while a free slot remains for the next response.
          if ((count_after_pop + CW'(1)) < DEPTH_C) state_d = ST_FETCH;
          else                                      state_d = ST_STALL;
        end
      end
      ST_STALL: begin
        if (redirect) begin
          fifo_flush = 1'b1;
          req_pc_d   = redirect_tgt;
          state_d    = ST_FETCH;
        end else if (fifo_pop) begin
          state_d = ST_FETCH;
        end
      end
      ST_DISCARD: begin
        if (redirect) begin
          fifo_flush = 1'b1;
          next_pc_d  = redirect_tgt;
          if (imem_ack) begin
            req_pc_d = redirect_tgt;
            state_d  = ST_FETCH;
          end
        end else if (imem_ack) begin
          req_pc_d = next_pc_q;
          state_d  = ST_FETCH;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!clrn) begin
      state_q   <= ST_IDLE;
      req_pc_q  <= RESET_PC;
      next_pc_q <= RESET_PC;
    end else begin
      state_q   <= state_d;
      req_pc_q  <= req_pc_d;
      next_pc_q <= next_pc_d;
    end
  end

  if_fetch_queue_inst_fifo #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(fetch_entry_t))
  ) u_inst_fifo (
    .clk     (clk),
    .clrn    (clrn),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .flush_i (fifo_flush),
    .data_i  (push_entry),
    .head_o  (fifo_head),
    .count_o (fifo_count)
  );

  assign imem_req  = (state_q == ST_FETCH) || (state_q == ST_DISCARD);
  assign imem_addr = req_pc_q;
  assign d_valid   = (fifo_count != '0);
  assign d_inst    = d_valid ? fifo_head.inst : NOP;
  assign d_pc      = d_valid ? fifo_head.pc   : 32'h0;
  assign q_count   = fifo_count;

endmodule

// File: tb/tb_if_fetch_queue.sv
module tb_if_fetch_queue;
  import if_fetch_queue_pkg::*;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] WRAP_PC  = 32'hFFFF_FFFC;

  logic        clk = 1'b0;
  logic        clrn;
  logic        imem_ack, redirect, d_ready;
  logic [31:0] imem_rdata, redirect_pc;

  logic        imem_req, d_valid;
  logic [31:0] imem_addr, d_inst, d_pc;
  logic [2:0]  q_count;

  logic        u2_req, u2_valid;
  logic [31:0] u2_addr, u2_inst, u2_pc;
  logic [2:0]  u2_count;

  always #5 clk = ~clk;

  if_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) u_dut (
    .clk(clk), .clrn(clrn),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .d_valid(d_valid), .d_ready(d_ready), .d_inst(d_inst), .d_pc(d_pc), .q_count(q_count)
  );

  // Second instance shares all inputs; it starts at the top of the address space.
  if_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(WRAP_PC)) u_dut_wrap (
    .clk(clk), .clrn(clrn),
    .imem_req(u2_req), .imem_addr(u2_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .d_valid(u2_valid), .d_ready(d_ready), .d_inst(u2_inst), .d_pc(u2_pc), .q_count(u2_count)
  );

  // Scoreboard: entries expected at the decode side, in order.
  fetch_entry_t exp_q[$];
  logic [31:0]  exp_addr;   // address expected on the live request
  logic [31:0]  exp_next;   // target after a discarded response
  bit           disc;       // outstanding response must be dropped
  int           n_tests = 0;
  int           n_fail  = 0;

  typedef struct {
    bit          rst;
    bit          ack;
    bit          ready;
    bit          redir;
    logic [31:0] rpc;
    int          exp_req;   // imem_req before the edge, -1 = not checked
    int          exp_cnt;   // q_count after the edge
  } vec_t;

  vec_t vt[$];

  function automatic vec_t v(input bit rst, input bit ack, input bit ready,
                             input int exp_req, input int exp_cnt);
    vec_t r;
    r.rst = rst; r.ack = ack; r.ready = ready; r.redir = 1'b0; r.rpc = 32'h0;
    r.exp_req = exp_req; r.exp_cnt = exp_cnt;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // One clock cycle: drive inputs, check the visible outputs against the
  // scoreboard, advance the model, clock, then check occupancy.
  task automatic cycle(input bit rst, input bit ack, input bit ready, input bit redir,
                       input logic [31:0] rpc, input int exp_req);
    logic [31:0]  rd;
    fetch_entry_t e;
    bit           req_exp;
    rd          = $urandom;
    clrn        = ~rst;
    imem_ack    = ack;
    imem_rdata  = rd;
    redirect    = redir;
    redirect_pc = rpc;
    d_ready     = ready;
    req_exp     = (exp_req > 0);
    if (rst) begin
      exp_q.delete();
      exp_addr = RESET_PC;
      exp_next = RESET_PC;
      disc     = 1'b0;
    end else begin
      if (exp_req >= 0) chk("imem_req", {31'b0, imem_req}, 32'(exp_req));
      chk("d_valid", {31'b0, d_valid}, {31'b0, exp_q.size() != 0});
      if (exp_q.size() == 0) begin
        chk("d_inst_nop", d_inst, NOP_INST);
        chk("d_pc_zero", d_pc, 32'h0);
      end else if (ready) begin
        e = exp_q.pop_front();
        chk("d_pc", d_pc, e.pc);
        chk("d_inst", d_inst, e.inst);
      end
      if (req_exp && ack) chk("imem_addr", imem_addr, exp_addr);
      if (redir) begin
        exp_q.delete();
        if (req_exp && !ack) begin
          disc     = 1'b1;
          exp_next = rpc & 32'hFFFF_FFFC;
        end else begin
          disc     = 1'b0;
          exp_addr = rpc & 32'hFFFF_FFFC;
        end
      end else if (req_exp && ack) begin
        if (disc) begin
          disc     = 1'b0;
          exp_addr = exp_next;
        end else begin
          exp_q.push_back('{pc: exp_addr, inst: rd});
          exp_addr = exp_addr + 32'd4;
        end
      end
    end
    $display("[TB] t=%0t rst=%0b ack=%0b rdy=%0b redir=%0b req=%0b addr=%h valid=%0b pc=%h cnt=%0d",
             $time, rst, ack, ready, redir, imem_req, imem_addr, d_valid, d_pc, q_count);
    @(posedge clk);
    #1;
    chk("q_count", {29'b0, q_count}, 32'(exp_q.size()));
  endtask

  initial begin
    clrn = 1'b0; imem_ack = 1'b0; redirect = 1'b0; d_ready = 1'b0;
    imem_rdata = 32'h0; redirect_pc = 32'h0;
    exp_addr = RESET_PC; exp_next = RESET_PC; disc = 1'b0;

    // Streaming with ack every cycle, then fill-to-stall and resume at 0x10.
    vt.push_back(v(1, 0, 1, -1, 0));
    vt.push_back(v(1, 0, 1, -1, 0));
    vt.push_back(v(0, 0, 1,  0, 0));
    vt.push_back(v(0, 1, 1,  1, 1));
    vt.push_back(v(0, 1, 1,  1, 1));
    vt.push_back(v(0, 1, 1,  1, 1));
    vt.push_back(v(0, 0, 1,  1, 0));
    vt.push_back(v(1, 0, 0, -1, 0));
    vt.push_back(v(0, 0, 0,  0, 0));
    vt.push_back(v(0, 1, 0,  1, 1));
    vt.push_back(v(0, 1, 0,  1, 2));
    vt.push_back(v(0, 1, 0,  1, 3));
    vt.push_back(v(0, 1, 0,  1, 4));
    vt.push_back(v(0, 0, 0,  0, 4));
    vt.push_back(v(0, 0, 1,  0, 3));
    vt.push_back(v(0, 1, 0,  1, 4));
    vt.push_back(v(0, 0, 1,  0, 3));
    vt.push_back(v(0, 0, 1,  1, 2));
    vt.push_back(v(0, 0, 1,  1, 1));
    vt.push_back(v(0, 0, 1,  1, 0));

    for (int i = 0; i < vt.size(); i++) begin
      cycle(vt[i].rst, vt[i].ack, vt[i].ready, vt[i].redir, vt[i].rpc, vt[i].exp_req);
      chk($sformatf("tbl_count[%0d]", i), {29'b0, q_count}, 32'(vt[i].exp_cnt));
    end

    // Redirect while the request waits for a slow ack.
    cycle(1, 0, 1, 0, 32'h0, -1);
    cycle(0, 0, 1, 0, 32'h0, 0);
    cycle(0, 0, 1, 1, 32'h0000_0103, 1);
    chk("disc_addr_hold1", imem_addr, 32'h0);
    cycle(0, 0, 1, 0, 32'h0, 1);
    chk("disc_addr_hold2", imem_addr, 32'h0);
    cycle(0, 1, 1, 0, 32'h0, 1);
    chk("disc_new_addr", imem_addr, 32'h0000_0100);
    chk("disc_no_valid", {31'b0, d_valid}, 32'h0);
    cycle(0, 1, 1, 0, 32'h0, 1);
    cycle(0, 0, 1, 0, 32'h0, 1);

    // Redirect and ack together with three entries queued.
    cycle(1, 0, 1, 0, 32'h0, -1);
    cycle(0, 0, 0, 0, 32'h0, 0);
    cycle(0, 1, 0, 0, 32'h0, 1);
    cycle(0, 1, 0, 0, 32'h0, 1);
    cycle(0, 1, 0, 0, 32'h0, 1);
    chk("pre_redir_count", {29'b0, q_count}, 32'd3);
    cycle(0, 1, 1, 1, 32'h0000_0200, 1);
    chk("redir_addr", imem_addr, 32'h0000_0200);
    cycle(0, 1, 1, 0, 32'h0, 1);
    cycle(0, 0, 1, 0, 32'h0, 1);
    cycle(0, 0, 1, 0, 32'h0, 1);

    // Reset in the middle of a request with two entries queued.
    cycle(1, 0, 1, 0, 32'h0, -1);
    cycle(0, 0, 0, 0, 32'h0, 0);
    cycle(0, 1, 0, 0, 32'h0, 1);
    cycle(0, 1, 0, 0, 32'h0, 1);
    cycle(0, 0, 0, 0, 32'h0, 1);
    cycle(1, 0, 0, 0, 32'h0, -1);
    chk("rst_valid", {31'b0, d_valid}, 32'h0);
    chk("rst_req", {31'b0, imem_req}, 32'h0);
    chk("rst_wrap_req", {31'b0, u2_req}, 32'h0);
    cycle(0, 0, 1, 0, 32'h0, 0);
    chk("wrap_addr0", u2_addr, WRAP_PC);
    chk("wrap_req", {31'b0, u2_req}, 32'h1);
    cycle(0, 1, 1, 0, 32'h0, 1);
    chk("wrap_addr1", u2_addr, 32'h0);
    chk("wrap_valid", {31'b0, u2_valid}, 32'h1);
    chk("wrap_dpc0", u2_pc, WRAP_PC);
    cycle(0, 1, 1, 0, 32'h0, 1);
    chk("wrap_addr2", u2_addr, 32'h4);
    chk("wrap_dpc1", u2_pc, 32'h0);
    cycle(0, 0, 1, 0, 32'h0, 1);
    cycle(0, 0, 1, 0, 32'h0, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
